// File: rtl/ram_share_pkg.sv
// rtl/ram_share_pkg.sv - shared constants and types for the RAM share controller
package ram_share_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_P0 = 1'b0,
    REQ_P1 = 1'b1
  } req_idx_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter; remembers the last granted port
module rr_arb2
  import ram_share_pkg::*;
(
  input  logic       clock_i,
  input  logic       resetn_i,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       gnt_en_i,
  output logic [1:0] gnt_o
);

  req_idx_e last_q;

  // On a tie the port that was not served last wins; reset favours port 0.
  always_comb begin
    gnt_o = 2'b00;
    if (gnt_en_i) begin
      if (req0_i && req1_i) begin
        gnt_o = (last_q == REQ_P1) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = {req1_i, req0_i};
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      last_q <= REQ_P1;
    end else if (gnt_o[1]) begin
      last_q <= REQ_P1;
    end else if (gnt_o[0]) begin
      last_q <= REQ_P0;
    end
  end

endmodule

// File: rtl/ram_share_ctrl.sv
// rtl/ram_share_ctrl.sv - shares one single-port RAM between two requesters
// Optional post-reset clear sweep: RAM_SHARE_CLEAR_EN
module ram_share_ctrl #(
  parameter int ADDR_W = ram_share_pkg::ADDR_W,
  parameter int DATA_W = ram_share_pkg::DATA_W
`ifdef RAM_SHARE_CLEAR_EN
  ,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
`endif
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  import ram_share_pkg::*;

  state_e            state_q;
  req_idx_e          win_q;
  logic              hold_we_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_wdata_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic              wren_q;
  logic [1:0]        gnt;

`ifdef RAM_SHARE_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              busy_q;
`endif

  rr_arb2 u_arb (
    .clock_i  (clock),
    .resetn_i (resetn),
    .req0_i   (req0),
    .req1_i   (req1),
    .gnt_en_i (state_q == ST_IDLE),
    .gnt_o    (gnt)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
`ifdef RAM_SHARE_CLEAR_EN
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
      wren_q    <= 1'b1;
`else
      state_q   <= ST_IDLE;
      wren_q    <= 1'b0;
`endif
      win_q        <= REQ_P0;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      wren_q    <= 1'b0;
      case (state_q)
`ifdef RAM_SHARE_CLEAR_EN
        ST_CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            wren_q    <= 1'b1;
          end
        end
`endif
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            state_q      <= ST_ISSUE;
            win_q        <= gnt[1] ? REQ_P1 : REQ_P0;
            hold_we_q    <= gnt[1] ? we1 : we0;
            hold_addr_q  <= gnt[1] ? addr1 : addr0;
            hold_wdata_q <= gnt[1] ? wdata1 : wdata0;
            wren_q       <= gnt[1] ? we1 : we0;
            ack0_q       <= gnt[0];
            ack1_q       <= gnt[1];
          end
        end
        ST_ISSUE: begin
          // RAM samples the address at the end of this cycle; data shows up in RESP.
          state_q   <= ST_RESP;
          rvalid0_q <= !hold_we_q && (win_q == REQ_P0);
          rvalid1_q <= !hold_we_q && (win_q == REQ_P1);
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    if (state_q == ST_ISSUE) begin
      mem_address = hold_addr_q;
      mem_data    = hold_wdata_q;
    end
`ifdef RAM_SHARE_CLEAR_EN
    else if (state_q == ST_CLEAR) begin
      mem_address = clr_cnt_q;
      mem_data    = CLEAR_VAL;
    end
`endif
  end

`ifdef RAM_SHARE_CLEAR_EN
  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  assign mem_wren = wren_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata    = mem_q;

endmodule

// File: tb/tb_ram_share_ctrl.sv
// tb/tb_ram_share_ctrl.sv - self-checking bench for ram_share_ctrl against a transaction-schedule model
module tb_ram_share_ctrl;

  localparam int AW   = 5;
  localparam int DW   = 4;
  localparam int NW   = 32;
  localparam int MAXC = 1024;
  localparam logic [DW-1:0] CLR_VAL = 4'h0;

  logic          clock;
  logic          resetn;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, rvalid0, rvalid1, busy, mem_wren;
  logic [DW-1:0] rdata, mem_data, mem_q;
  logic [AW-1:0] mem_address;

  int nvec = 0;
  int nerr = 0;

  ram_share_ctrl dut (
    .clock(clock), .resetn(resetn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single-port RAM with one-cycle read latency.
  bit [DW-1:0] ram [NW];
  always @(posedge clock) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  // Model: per-cycle expected outputs, scheduled when an access is accepted.
  bit          e_ack0 [MAXC];
  bit          e_ack1 [MAXC];
  bit          e_rv0  [MAXC];
  bit          e_rv1  [MAXC];
  bit          e_wren [MAXC];
  bit          e_busy [MAXC];
  bit [AW-1:0] e_addr [MAXC];
  bit [DW-1:0] e_data [MAXC];
  bit [DW-1:0] e_rdat [MAXC];
  bit [DW-1:0] shadow [NW];
  int          cyc = 0;
  int          idle_from = 0;
  bit          last_m = 1'b1;

  always @(posedge clock) begin
    int n;
    bit w;
    n = cyc;
    if (n < MAXC && e_wren[n]) shadow[e_addr[n]] = e_data[n];
    if (!resetn) begin
      for (int k = n + 1; k < n + 40 && k < MAXC; k++) begin
        e_ack0[k] = 0; e_ack1[k] = 0; e_rv0[k] = 0; e_rv1[k] = 0;
        e_wren[k] = 0; e_busy[k] = 0; e_addr[k] = '0; e_data[k] = '0; e_rdat[k] = '0;
      end
      last_m = 1'b1;
`ifdef RAM_SHARE_CLEAR_EN
      for (int k = 0; k < NW; k++) begin
        if (n + 1 + k < MAXC) begin
          e_wren[n+1+k] = 1; e_busy[n+1+k] = 1;
          e_addr[n+1+k] = AW'(k); e_data[n+1+k] = CLR_VAL;
        end
      end
      idle_from = n + 1 + NW;
`else
      idle_from = n + 1;
`endif
    end else if (n >= idle_from && (req0 || req1) && n + 3 < MAXC) begin
      w = (req0 && req1) ? !last_m : req1;
      if (w) e_ack1[n+1] = 1; else e_ack0[n+1] = 1;
      e_wren[n+1] = w ? we1 : we0;
      e_addr[n+1] = w ? addr1 : addr0;
      e_data[n+1] = w ? wdata1 : wdata0;
      if (!(w ? we1 : we0)) begin
        if (w) e_rv1[n+2] = 1; else e_rv0[n+2] = 1;
        e_rdat[n+2] = shadow[w ? addr1 : addr0];
      end
      last_m = w;
      idle_from = n + 3;
    end
    cyc = n + 1;
  end

  always @(negedge clock) begin
    if (cyc >= 1 && cyc < MAXC) begin
      nvec++;
      if (ack0 !== e_ack0[cyc] || ack1 !== e_ack1[cyc] || rvalid0 !== e_rv0[cyc] ||
          rvalid1 !== e_rv1[cyc] || mem_wren !== e_wren[cyc] || busy !== e_busy[cyc] ||
          mem_address !== e_addr[cyc] || mem_data !== e_data[cyc] ||
          ((e_rv0[cyc] || e_rv1[cyc]) && rdata !== e_rdat[cyc])) begin
        nerr++;
        $display("FAIL model cycle %0d: got ack=%b%b rv=%b%b wren=%b addr=%0d data=%h busy=%b rdata=%h, need ack=%b%b rv=%b%b wren=%b addr=%0d data=%h busy=%b rdata=%h",
                 cyc, ack1, ack0, rvalid1, rvalid0, mem_wren, mem_address, mem_data, busy, rdata,
                 e_ack1[cyc], e_ack0[cyc], e_rv1[cyc], e_rv0[cyc], e_wren[cyc], e_addr[cyc],
                 e_data[cyc], e_busy[cyc], e_rdat[cyc]);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h, need %0h", nm, act, expv);
    end
  endtask

  task automatic tie(output int t0, output int t1);
    t0 = -1; t1 = -1;
    req0 = 1; req1 = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (ack0) begin t0 = k; req0 = 0; end
      if (ack1) begin t1 = k; req1 = 0; end
      if (t0 > 0 && t1 > 0) break;
    end
    req0 = 0; req1 = 0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, bc, got;
    resetn = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clock);
    resetn = 1;

`ifdef RAM_SHARE_CLEAR_EN
    lit("reset_busy", busy, 1);
    lit("reset_wren", mem_wren, 1);
    lit("reset_addr", mem_address, 0);
    bc = 0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      bc++;
      if (bc == 5) begin we1 = 0; addr1 = 5'd7; req1 = 1; end
      @(negedge clock);
    end
    lit("clear_cycles", bc, 32);
    @(negedge clock);
    lit("clear_pending_ack1", ack1, 1);
    req1 = 0;
    @(negedge clock);
    lit("clear_rvalid1", rvalid1, 1);
    lit("clear_rdata", rdata, 0);
    @(negedge clock);
`else
    lit("reset_busy", busy, 0);
    lit("reset_wren", mem_wren, 0);
`endif

    we0 = 1; addr0 = 5'd3; wdata0 = 4'hA; req0 = 1;
    @(negedge clock);
    lit("wr_ack0", ack0, 1);
    lit("wr_ack1", ack1, 0);
    lit("wr_wren", mem_wren, 1);
    lit("wr_addr", mem_address, 3);
    lit("wr_data", mem_data, 4'hA);
    req0 = 0;
    @(negedge clock);
    lit("wr_no_rvalid", rvalid0, 0);
    @(negedge clock);

    we1 = 0; addr1 = 5'd3; req1 = 1;
    @(negedge clock);
    lit("rd_ack1", ack1, 1);
    req1 = 0;
    @(negedge clock);
    lit("rd_rvalid1", rvalid1, 1);
    lit("rd_rdata", rdata, 4'hA);
    @(negedge clock);

    we0 = 0; addr0 = 5'd3; we1 = 1; addr1 = 5'd9; wdata1 = 4'h5;
    tie(t0, t1);
    lit("tie1_ack0_at", t0, 1);
    lit("tie1_ack1_at", t1, 4);
    we0 = 0; addr0 = 5'd9; we1 = 0; addr1 = 5'd3;
    tie(t0, t1);
    lit("tie2_ack0_at", t0, 1);
    lit("tie2_ack1_at", t1, 4);

    we1 = 0; addr1 = 5'd9; req1 = 1;
    @(negedge clock);
    lit("rst_issue_ack1", ack1, 1);
    resetn = 0;
    @(negedge clock);
    lit("rst_no_rvalid", rvalid1, 0);
`ifdef RAM_SHARE_CLEAR_EN
    lit("rst_sweep_addr", mem_address, 0);
    lit("rst_sweep_busy", busy, 1);
`endif
    resetn = 1;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (ack1) begin got = 1; break; end
    end
    lit("rst_held_served", got, 1);
    req1 = 0;
    @(negedge clock);
    lit("rst_rvalid1", rvalid1, 1);
`ifdef RAM_SHARE_CLEAR_EN
    lit("rst_rdata", rdata, 0);
`else
    lit("rst_rdata", rdata, 4'h5);
`endif
    @(negedge clock);

    we0 = 0; addr0 = 5'd3; req0 = 1;
    @(negedge clock);
    lit("keep_ack0", ack0, 1);
    req0 = 0;
    @(negedge clock);
    lit("keep_rvalid0", rvalid0, 1);
`ifdef RAM_SHARE_CLEAR_EN
    lit("keep_rdata", rdata, 0);
`else
    lit("keep_rdata", rdata, 4'hA);
`endif
    repeat (4) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
